// File: rtl/control_magn_pwm_if.sv
// Keypad/timer-side bundle for the magnetron duty-cycle controller.
// The master drives the cook requests; the slave (the controller) drives the magnetron status.
interface control_magn_pwm_if #(
  parameter int PWR_W = 4
);
  logic             startn;
  logic             stopn;
  logic             clearn;
  logic             door_closed;
  logic             timer_done;
  logic [PWR_W-1:0] power_level;
  logic             mag_on;
  logic [1:0]       state;
  logic             done;

  modport master (
    output startn, stopn, clearn, door_closed, timer_done, power_level,
    input  mag_on, state, done
  );

  modport slave (
    input  startn, stopn, clearn, door_closed, timer_done, power_level,
    output mag_on, state, done
  );
endinterface

// File: rtl/control_magn_pwm.sv
// Magnetron cook-state machine with pause/resume, done pulse and slot-based duty-cycle power.
// Define MAG_LIVE_POWER_EN to reload the power latch from power_level at every window wrap.
module control_magn_pwm #(
  parameter int PWR_W       = 4,
  parameter int PERIOD      = 10,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  control_magn_pwm_if.slave   bus
);
  localparam int SLOT_W = $clog2(PERIOD);
  localparam int CYC_W  = $clog2(SLOT_CYCLES);
  localparam int LAT_W  = $clog2(PERIOD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [CYC_W-1:0]  r_cyc_cnt;
  logic [SLOT_W-1:0] r_slot_idx;
  logic [LAT_W-1:0]  r_pwr_lat;
  logic [LAT_W-1:0]  w_pwr_req;
  logic [PWR_W-1:0]  w_power;
  logic              r_done;
  logic              w_cyc_wrap;
  logic              w_slot_wrap;
  logic              w_advance;
  logic              w_clear;

  assign w_power = bus.power_level;

  always_comb begin
    if (int'(w_power) >= PERIOD) w_pwr_req = LAT_W'(PERIOD);
    else                         w_pwr_req = LAT_W'(w_power);
  end

  // NOTE: w_next gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.startn && bus.door_closed && bus.stopn && bus.clearn &&
            !bus.timer_done && (w_power != '0))
          w_next = S_COOK;
      end
      S_COOK: begin
        if (!bus.clearn)                         w_next = S_IDLE;
        else if (bus.timer_done)                 w_next = S_DONE;
        else if (!bus.door_closed || !bus.stopn) w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (!bus.clearn)                                        w_next = S_IDLE;
        else if (bus.timer_done)                                w_next = S_DONE;
        else if (!bus.startn && bus.door_closed && bus.stopn)   w_next = S_COOK;
      end
      default: begin
        if (!bus.clearn || !bus.door_closed) w_next = S_IDLE;
      end
    endcase
  end

  // The edge that leaves COOK does not advance the window, so a resume picks up exactly where mag_on stopped.
  assign w_advance   = (r_state == S_COOK) && (w_next == S_COOK);
  assign w_clear     = (r_state == S_IDLE) || (r_state == S_DONE) ||
                       (w_next == S_IDLE)  || (w_next == S_DONE);
  assign w_cyc_wrap  = (r_cyc_cnt == CYC_W'(SLOT_CYCLES - 1));
  assign w_slot_wrap = (r_slot_idx == SLOT_W'(PERIOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cyc_cnt  <= '0;
      r_slot_idx <= '0;
    end else if (w_advance) begin
      if (w_cyc_wrap) begin
        r_cyc_cnt  <= '0;
        r_slot_idx <= w_slot_wrap ? '0 : r_slot_idx + 1'b1;
      end else begin
        r_cyc_cnt  <= r_cyc_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwr_lat <= '0;
    end else if ((r_state == S_IDLE) && (w_next == S_COOK)) begin
      r_pwr_lat <= w_pwr_req;
`ifdef MAG_LIVE_POWER_EN
    end else if (w_advance && w_cyc_wrap && w_slot_wrap) begin
      r_pwr_lat <= w_pwr_req;
`else
    end else begin
      r_pwr_lat <= r_pwr_lat;
`endif
    end
  end

  // Door term stays combinational so an opening door kills the magnetron in the same cycle.
  assign bus.mag_on = (r_state == S_COOK) && (int'(r_slot_idx) < int'(r_pwr_lat)) &&
                      bus.door_closed;
  assign bus.state  = r_state;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_control_magn_pwm.sv
// Randomized scoreboard bench for control_magn_pwm against a window-position reference model.
module tb_control_magn_pwm;
  localparam int PWR_W       = 4;
  localparam int PERIOD      = 10;
  localparam int SLOT_CYCLES = 4;
  localparam int WIN         = PERIOD * SLOT_CYCLES;

  typedef struct {
    logic [1:0] st;
    logic       mag;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  control_magn_pwm_if #(.PWR_W(PWR_W)) bus();

  control_magn_pwm #(
    .PWR_W(PWR_W), .PERIOD(PERIOD), .SLOT_CYCLES(SLOT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: state 0..3, position inside the modulation window, latched power.
  int m_st   = 0;
  int m_pos  = 0;
  int m_lat  = 0;
  bit m_done = 0;

  function automatic int clip(input int p);
    return (p > PERIOD) ? PERIOD : p;
  endfunction

  function automatic void model_update();
    int nxt;
    int pl;
    pl = int'(bus.power_level);
    if (rst) begin
      m_st = 0; m_pos = 0; m_lat = 0; m_done = 0;
      return;
    end
    nxt = m_st;
    case (m_st)
      0: if (!bus.startn && bus.door_closed && bus.stopn && bus.clearn && !bus.timer_done && pl != 0) nxt = 1;
      1: if (!bus.clearn) nxt = 0; else if (bus.timer_done) nxt = 3;
         else if (!bus.door_closed || !bus.stopn) nxt = 2;
      2: if (!bus.clearn) nxt = 0; else if (bus.timer_done) nxt = 3;
         else if (!bus.startn && bus.door_closed && bus.stopn) nxt = 1;
      default: if (!bus.clearn || !bus.door_closed) nxt = 0;
    endcase
    m_done = (nxt == 3) && (m_st != 3);
    if (m_st == 0 && nxt == 1) m_lat = clip(pl);
    if (m_st == 1 && nxt == 1) begin
      m_pos = (m_pos + 1) % WIN;
`ifdef MAG_LIVE_POWER_EN
      if (m_pos == 0) m_lat = clip(pl);
`endif
    end else if (nxt == 0 || nxt == 3) begin
      m_pos = 0;
    end
    m_st = nxt;
  endfunction

  task automatic step(input logic r, input logic s, input logic p, input logic c,
                      input logic d, input logic t, input logic [PWR_W-1:0] pl);
    exp_t e;
    @(posedge clk);
    model_update();
    #1;
    rst = r;
    bus.startn = s; bus.stopn = p; bus.clearn = c;
    bus.door_closed = d; bus.timer_done = t; bus.power_level = pl;
    e.st   = 2'(m_st);
    e.mag  = (m_st == 1) && d && ((m_pos / SLOT_CYCLES) < m_lat);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n, input logic [PWR_W-1:0] pl);
    for (int i = 0; i < n; i++) step(0, 1, 1, 1, 1, 0, pl);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state",  bus.state,          e.st);
        check("mag_on", {1'b0, bus.mag_on}, {1'b0, e.mag});
        check("done",   {1'b0, bus.done},   {1'b0, e.done});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
    bus.door_closed = 1'b1; bus.timer_done = 1'b0; bus.power_level = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), PWR_W'($urandom));
    idle_steps(2, 0);

    // Power 5 for three windows
    step(0, 0, 1, 1, 1, 0, 5);
    idle_steps(3 * WIN, 5);
    step(0, 1, 1, 0, 1, 0, 5);

    // Door opens at cook cycle 7, then resume
    step(0, 0, 1, 1, 1, 0, 5);
    idle_steps(7, 5);
    step(0, 1, 1, 1, 0, 0, 5);
    step(0, 1, 1, 1, 0, 0, 5);
    step(0, 0, 1, 1, 1, 0, 5);
    idle_steps(WIN, 5);

    // Timer expiry, start ignored in DONE, door open returns to IDLE
    step(0, 1, 1, 1, 1, 1, 5);
    step(0, 0, 1, 1, 1, 0, 5);
    step(0, 0, 1, 1, 1, 0, 5);
    step(0, 1, 1, 1, 0, 0, 5);
    idle_steps(2, 5);

    // Timer and clear together: no done pulse
    step(0, 0, 1, 1, 1, 0, 7);
    idle_steps(5, 7);
    step(0, 1, 1, 0, 1, 1, 7);
    idle_steps(3, 7);

    // Start and stop together, then stop releases with start held
    step(0, 0, 0, 1, 1, 0, 6);
    step(0, 0, 1, 1, 1, 0, 6);
    idle_steps(6, 6);
    step(0, 0, 0, 1, 1, 0, 6);
    step(0, 0, 0, 1, 1, 0, 6);
    step(0, 0, 1, 1, 1, 0, 6);
    idle_steps(10, 6);
    step(0, 1, 1, 0, 1, 0, 6);

    // Over-range power saturates; zero power start is ignored
    step(0, 0, 1, 1, 1, 0, 15);
    idle_steps(2 * WIN, 15);
    step(0, 1, 1, 0, 1, 0, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0, 0);

    // Power change mid-cook (reloaded only with live power)
    step(0, 0, 1, 1, 1, 0, 10);
    idle_steps(WIN / 2, 10);
    idle_steps(WIN + WIN / 2, 3);
    idle_steps(WIN, 0);
    step(0, 1, 1, 0, 1, 0, 0);

    // Reset mid-cook
    step(0, 0, 1, 1, 1, 0, 8);
    idle_steps(5, 8);
    step(1, 1, 1, 1, 1, 1, 8);
    idle_steps(3, 8);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(99) >= 30,
           $urandom_range(99) >= 5,
           $urandom_range(99) >= 3,
           $urandom_range(99) >= 5,
           $urandom_range(99) < 3,
           ($urandom_range(19) == 0) ? PWR_W'($urandom) : bus.power_level);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/control_magn_pwm.md
Name: control_magn_pwm

Overview:
Clocked, parametrised successor to the magnetron on/off latch. It adds a cook-state machine with pause/resume and a done indication. Power level is implemented by duty-cycle modulation of mag_on over a fixed window of slots. The block sits between the keypad/timer logic and the magnetron driver. The door interlock is enforced directly on the output.

Parameters:
PWR_W, 4, width of power_level input
PERIOD, 10, slots per modulation window (full power = PERIOD)
SLOT_CYCLES, 4, clk cycles per slot

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
startn  input  1  start request, active-low level, sampled each clk
stopn  input  1  pause request, active-low level
clearn  input  1  cancel request, active-low level
door_closed  input  1  1 = door closed
timer_done  input  1  cook timer expired, level
power_level  input  PWR_W  requested power, in slots per window
mag_on  output  1  magnetron enable
state  output  2  0=IDLE 1=COOK 2=PAUSE 3=DONE
done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset, one clk edge with rst=1:
  - state=IDLE, counters=0, pwr_lat=0, done=0.
  - mag_on=0 from the cycle after the reset edge.
- Counters:
  - cyc_cnt runs 0..SLOT_CYCLES-1. slot_idx runs 0..PERIOD-1, width $clog2(PERIOD).
  - In COOK, cyc_cnt increments each clk. On wrap, slot_idx increments. slot_idx wraps PERIOD-1 to 0.
  - Counters hold in PAUSE. They clear to 0 in IDLE and DONE.
- Power latch:
  - pwr_lat = min(power_level, PERIOD), captured on the IDLE to COOK edge.
  - A start with power_level=0 is ignored; the block stays in IDLE.
- mag_on = (state==COOK) & (slot_idx < pwr_lat) & door_closed.
  - The door term is combinational, so door opening forces mag_on=0 in the same cycle.
- Latency: startn sampled low at edge N gives state=COOK and mag_on=1 after edge N (pwr_lat>0).
- Transitions, evaluated every edge, priority top-down within each state:
  - IDLE: startn=0 & door_closed=1 & stopn=1 & clearn=1 & timer_done=0 & power_level!=0 -> COOK.
  - COOK: clearn=0 -> IDLE; timer_done=1 -> DONE; door_closed=0 or stopn=0 -> PAUSE; else stay.
  - PAUSE:
    - clearn=0 -> IDLE; timer_done=1 -> DONE.
    - startn=0 & door_closed=1 & stopn=1 -> COOK, resuming with cyc_cnt/slot_idx/pwr_lat retained.
    - Otherwise stay.
  - DONE:
    - clearn=0 or door_closed=0 -> IDLE.
    - startn ignored.
    - done=1 only in the first cycle after entry.
- Simultaneous events:
  - clearn beats everything: no done pulse if clearn=0 with timer_done=1.
  - startn and stopn both low -> no start; in COOK, stop wins.
- startn held low is level-sensitive. After a stop releases while startn is still low, the block restarts from PAUSE.
- rst mid-cook has the same effect as at power-up: mag_on=0 after the edge, no done pulse.

Optional Feature:
MAG_LIVE_POWER_EN
- Defined: pwr_lat is also reloaded from min(power_level, PERIOD) whenever slot_idx wraps to 0 in COOK.
  - power_level=0 at reload keeps state=COOK with mag_on=0.
- Undefined: pwr_lat is loaded only on IDLE to COOK; power_level changes during cook/pause are ignored.

Test Plan (PERIOD=10, SLOT_CYCLES=4, PWR_W=4):
1. rst=1 for 3 cycles with random inputs -> state=0, mag_on=0, done=0 after each edge.
2. power_level=5, door_closed=1, startn=0 for 1 cycle -> state=1 next cycle; mag_on 1 for 20 cycles, then 0 for 20 cycles, repeating for 3 windows.
3. Power 5 cook; door_closed=0 at cook cycle 7 -> mag_on=0 that cycle, state=2 next edge. Close door and pulse startn -> state=1, mag_on high for exactly 13 more cycles before the off phase.
4. In COOK, timer_done=1 -> state=3, done=1 for exactly 1 cycle, mag_on=0. startn=0 is ignored. door_closed=0 -> state=0.
5. timer_done=1 and clearn=0 in the same cycle during COOK -> state=0, done stays 0.
6. power_level=15 -> pwr_lat=10, mag_on constantly 1 for 2 windows. power_level=0 with startn=0 -> state stays 0. With MAG_LIVE_POWER_EN, change 10 to 3 mid-window -> next window has 12 on cycles.
